// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store initiator between the execute stage and a word-granular
// data memory. Byte/half/word loads and stores over a valid/ready request port;
// sub-word stores are done as read-modify-write. Responses are a single-cycle
// pulse with no backpressure.
//
// Optional feature macro: LSU_MISALIGN_TRAP_EN
//   defined   : misaligned half/word and size=11 requests return rsp_err_o=1
//               after one cycle and never touch memory.
//   undefined : rsp_err_o is tied 0, misaligned addresses are forced aligned,
//               size=11 is treated as a word access.
//
// Handshake: a request is accepted in any cycle where req_valid_i and
// req_ready_o are both 1; the requester holds its request stable until then.
// req_ready_o is high only in IDLE (and never while rst_i is high).
module lsu_ctrl #(
  parameter int ADDR_W = 5,
  parameter int XLEN   = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [1:0]        req_size_i,
  input  logic              req_unsigned_i,
  input  logic [ADDR_W+1:0] req_addr_i,
  input  logic [XLEN-1:0]   req_wdata_i,
  output logic              rsp_valid_o,
  output logic [XLEN-1:0]   rsp_rdata_o,
  output logic              rsp_err_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [XLEN-1:0]   mem_wdata_o,
  input  logic [XLEN-1:0]   mem_rdata_i,
  output logic [1:0]        dbg_state
);

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    RSP  = 2'd3
  } state_t;

  state_t state;
  state_t state_next;

  // Latched request and the word read back for loads / read-modify-write.
  logic              op_we;
  logic [1:0]        op_size;
  logic              op_uns;
  logic [ADDR_W+1:0] op_addr;
  logic [XLEN-1:0]   op_wdata;
  logic              op_err;
  logic [XLEN-1:0]   word_buf;

  // Decoded view of the incoming request.
  logic              accept;
  logic              req_err;
  logic [1:0]        req_size_n;
  logic [ADDR_W+1:0] req_addr_n;

  // Data path helpers.
  logic [7:0]        byte_sel;
  logic [15:0]       half_sel;
  logic [XLEN-1:0]   load_data;
  logic [XLEN-1:0]   merge_data;

  assign accept    = req_valid_i && req_ready_o;
  assign dbg_state = state;

  // Classify the request: error detection or alignment fix-up.
  always_comb begin
    req_err    = 1'b0;
    req_size_n = req_size_i;
    req_addr_n = req_addr_i;
`ifdef LSU_MISALIGN_TRAP_EN
    req_err = (req_size_i == 2'b11) ||
              ((req_size_i == SZ_HALF) && req_addr_i[0]) ||
              ((req_size_i == SZ_WORD) && (req_addr_i[1:0] != 2'b00));
`else
    if (req_size_i == 2'b11) req_size_n = SZ_WORD;
    if (req_size_n == SZ_HALF) req_addr_n[0] = 1'b0;
    if (req_size_n == SZ_WORD) req_addr_n[1:0] = 2'b00;
`endif
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (req_err)                    state_next = RSP;
          else if (!req_we_i)             state_next = RD;
          else if (req_size_n == SZ_WORD) state_next = WR;
          else                            state_next = RD;
        end
      end
      RD:      state_next = op_we ? WR : RSP;
      WR:      state_next = RSP;
      RSP:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Request latch on accept and read-data capture at the end of RD.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      op_we    <= 1'b0;
      op_size  <= SZ_BYTE;
      op_uns   <= 1'b0;
      op_addr  <= '0;
      op_wdata <= '0;
      op_err   <= 1'b0;
      word_buf <= '0;
    end else begin
      if (accept) begin
        op_we    <= req_we_i;
        op_size  <= req_size_n;
        op_uns   <= req_unsigned_i;
        op_addr  <= req_addr_n;
        op_wdata <= req_wdata_i;
        op_err   <= req_err;
      end
      if (state == RD) word_buf <= mem_rdata_i;
    end
  end

  // Lane extraction and extension for loads, lane merge for sub-word stores.
  always_comb begin
    case (op_addr[1:0])
      2'd0:    byte_sel = word_buf[7:0];
      2'd1:    byte_sel = word_buf[15:8];
      2'd2:    byte_sel = word_buf[23:16];
      default: byte_sel = word_buf[31:24];
    endcase
    half_sel = op_addr[1] ? word_buf[31:16] : word_buf[15:0];

    case (op_size)
      SZ_BYTE: load_data = op_uns ? {{(XLEN-8){1'b0}}, byte_sel}
                                  : {{(XLEN-8){byte_sel[7]}}, byte_sel};
      SZ_HALF: load_data = op_uns ? {{(XLEN-16){1'b0}}, half_sel}
                                  : {{(XLEN-16){half_sel[15]}}, half_sel};
      default: load_data = word_buf;
    endcase

    merge_data = word_buf;
    if (op_size == SZ_BYTE) begin
      case (op_addr[1:0])
        2'd0:    merge_data[7:0]   = op_wdata[7:0];
        2'd1:    merge_data[15:8]  = op_wdata[7:0];
        2'd2:    merge_data[23:16] = op_wdata[7:0];
        default: merge_data[31:24] = op_wdata[7:0];
      endcase
    end else if (op_size == SZ_HALF) begin
      if (op_addr[1]) merge_data[31:16] = op_wdata[15:0];
      else            merge_data[15:0]  = op_wdata[15:0];
    end
  end

  // Moore outputs; everything is forced idle while reset is asserted so a
  // pending write is never committed and no response escapes.
  always_comb begin
    req_ready_o = (state == IDLE) && !rst_i;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    rsp_valid_o = 1'b0;
    rsp_rdata_o = '0;
    rsp_err_o   = 1'b0;
    if (!rst_i) begin
      case (state)
        RD: begin
          mem_addr_o = op_addr[ADDR_W+1:2];
        end
        WR: begin
          mem_we_o    = 1'b1;
          mem_addr_o  = op_addr[ADDR_W+1:2];
          mem_wdata_o = (op_size == SZ_WORD) ? op_wdata : merge_data;
        end
        RSP: begin
          rsp_valid_o = 1'b1;
          rsp_err_o   = op_err;
          rsp_rdata_o = (!op_we && !op_err) ? load_data : '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl with a 32-word behavioural memory.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the
// falling edge. Cycle k of a transaction is the k-th cycle after the accept cycle.
module tb_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [6:0]  req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_we;
  logic [4:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic [1:0]  dbg_state;

  logic [31:0] mem [32];
  logic        pre_we;
  logic [4:0]  pre_addr;
  logic [31:0] pre_data;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];

  // ---------------- clock / reset / memory ----------------
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we)      mem[mem_addr] <= mem_wdata;
    else if (pre_we) mem[pre_addr] <= pre_data;
  end
  assign mem_rdata = mem[mem_addr];

  lsu_ctrl #(.ADDR_W(5), .XLEN(32)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .req_valid_i    (req_valid),
    .req_ready_o    (req_ready),
    .req_we_i       (req_we),
    .req_size_i     (req_size),
    .req_unsigned_i (req_unsigned),
    .req_addr_i     (req_addr),
    .req_wdata_i    (req_wdata),
    .rsp_valid_o    (rsp_valid),
    .rsp_rdata_o    (rsp_rdata),
    .rsp_err_o      (rsp_err),
    .mem_we_o       (mem_we),
    .mem_addr_o     (mem_addr),
    .mem_wdata_o    (mem_wdata),
    .mem_rdata_i    (mem_rdata),
    .dbg_state      (dbg_state)
  );

  // ---------------- driver tasks ----------------
  task automatic preload(input logic [4:0] a, input logic [31:0] d);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    @(posedge clk); #1;
    pre_we = 1'b0;
  endtask

  // Issue one request (entered 1 unit after a rising edge) and observe 5 cycles.
  task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                        input logic [6:0] addr, input logic [31:0] wdata,
                        output logic rdy, output int lat, output int pulses,
                        output logic [31:0] rdata, output logic err,
                        output int we_cyc, output logic [4:0] waddr,
                        output logic [31:0] wd, output logic [4:0] addr1);
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    @(negedge clk);
    rdy = req_ready;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0; pulses = 0; rdata = 32'h0; err = 1'b0;
    we_cyc = 0; waddr = 5'h0; wd = 32'h0; addr1 = 5'h0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k == 1) addr1 = mem_addr;
      if (rsp_valid) begin
        pulses++;
        if (lat == 0) begin lat = k; rdata = rsp_rdata; err = rsp_err; end
      end
      if (mem_we && we_cyc == 0) begin we_cyc = k; waddr = mem_addr; wd = mem_wdata; end
      @(posedge clk); #1;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b0 || rsp_valid !== 1'b0 || rsp_err !== 1'b0 || mem_we !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got ready=%b rsp_valid=%b err=%b we=%b, expected all 0",
               req_ready, rsp_valid, rsp_err, mem_we);
    end
    checks++;
    if (rsp_rdata !== 32'h0 || mem_addr !== 5'h0 || mem_wdata !== 32'h0 || dbg_state !== 2'd0) begin
      errors++;
      $display("FAIL reset_data: got rdata=%h addr=%h wdata=%h state=%0d, expected 0",
               rsp_rdata, mem_addr, mem_wdata, dbg_state);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: got %b expected 1", req_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_load();
    logic [1:0]  sz  [6];
    logic        un  [6];
    logic [6:0]  ad  [6];
    logic [31:0] ex  [6];
    logic rdy, err; int lat, pulses, we_cyc;
    logic [31:0] rd, wd; logic [4:0] wa, a1;
    sz[0] = 2'd0; un[0] = 1'b0; ad[0] = 7'h0D; ex[0] = 32'h00000066;
    sz[1] = 2'd0; un[1] = 1'b0; ad[1] = 7'h0F; ex[1] = 32'hFFFFFF88;
    sz[2] = 2'd0; un[2] = 1'b1; ad[2] = 7'h0F; ex[2] = 32'h00000088;
    sz[3] = 2'd1; un[3] = 1'b0; ad[3] = 7'h0E; ex[3] = 32'hFFFF8877;
    sz[4] = 2'd1; un[4] = 1'b1; ad[4] = 7'h0C; ex[4] = 32'h00006655;
    sz[5] = 2'd2; un[5] = 1'b0; ad[5] = 7'h0C; ex[5] = 32'h88776655;
    for (int i = 0; i < 6; i++) begin
      do_req(1'b0, sz[i], un[i], ad[i], 32'h0, rdy, lat, pulses, rd, err, we_cyc, wa, wd, a1);
      checks++;
      if (rdy !== 1'b1 || lat != 2 || pulses != 1) begin
        errors++;
        $display("FAIL load%0d_timing: got ready=%b lat=%0d pulses=%0d expected 1/2/1",
                 i, rdy, lat, pulses);
      end
      checks++;
      if (rd !== ex[i] || err !== 1'b0) begin
        errors++;
        $display("FAIL load%0d_data: got %h err=%b expected %h err=0", i, rd, err, ex[i]);
      end
      checks++;
      if (we_cyc != 0 || a1 !== 5'd3) begin
        errors++;
        $display("FAIL load%0d_mem: got we_cycle=%0d addr=%0d expected 0/3", i, we_cyc, a1);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] sz [3];
    logic       un [3];
    logic [6:0] ad [3];
    int acc [3];
    int idx, pulses, ready_cnt;
    logic [31:0] e;
    sz[0] = 2'd2; un[0] = 1'b0; ad[0] = 7'h0C;
    sz[1] = 2'd0; un[1] = 1'b1; ad[1] = 7'h0D;
    sz[2] = 2'd1; un[2] = 1'b0; ad[2] = 7'h0E;
    exp_q.push_back(32'h88776655);
    exp_q.push_back(32'h00000066);
    exp_q.push_back(32'hFFFF8877);
    for (int i = 0; i < 3; i++) acc[i] = -1;
    idx = 0; pulses = 0; ready_cnt = 0;
    req_we = 1'b0; req_wdata = 32'h0;
    req_valid = 1'b1; req_size = sz[0]; req_unsigned = un[0]; req_addr = ad[0];
    for (int c = 0; c < 12; c++) begin
      logic took;
      took = 1'b0;
      @(negedge clk);
      if (req_ready && c <= 8) ready_cnt++;
      if (req_ready && idx < 3) begin acc[idx] = c; took = 1'b1; end
      if (rsp_valid) begin
        pulses++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL b2b_extra_rsp: got rsp at cycle %0d expected none", c);
        end else begin
          e = exp_q.pop_front();
          if (rsp_rdata !== e) begin
            errors++;
            $display("FAIL b2b_data: got %h expected %h", rsp_rdata, e);
          end
        end
      end
      @(posedge clk); #1;
      if (took) begin
        idx++;
        if (idx < 3) begin
          req_size = sz[idx]; req_unsigned = un[idx]; req_addr = ad[idx];
        end else begin
          req_valid = 1'b0;
        end
      end
    end
    req_valid = 1'b0;
    checks++;
    if (acc[0] != 0 || acc[1] != 3 || acc[2] != 6) begin
      errors++;
      $display("FAIL b2b_accepts: got %0d,%0d,%0d expected 0,3,6", acc[0], acc[1], acc[2]);
    end
    checks++;
    if (pulses != 3 || ready_cnt != 3 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL b2b_counts: got pulses=%0d ready_cycles=%0d left=%0d expected 3/3/0",
               pulses, ready_cnt, exp_q.size());
    end
  endtask

  task automatic test_store_half();
    logic rdy, err; int lat, pulses, we_cyc;
    logic [31:0] rd, wd; logic [4:0] wa, a1;
    do_req(1'b1, 2'd1, 1'b0, 7'h0E, 32'h1234BEEF, rdy, lat, pulses, rd, err, we_cyc, wa, wd, a1);
    checks++;
    if (a1 !== 5'd3 || we_cyc != 2) begin
      errors++;
      $display("FAIL sh_read_phase: got addr=%0d we_cycle=%0d expected 3/2", a1, we_cyc);
    end
    checks++;
    if (wa !== 5'd3 || wd !== 32'hBEEF6655) begin
      errors++;
      $display("FAIL sh_write: got addr=%0d data=%h expected 3/beef6655", wa, wd);
    end
    checks++;
    if (lat != 3 || pulses != 1 || rd !== 32'h0 || err !== 1'b0) begin
      errors++;
      $display("FAIL sh_rsp: got lat=%0d pulses=%0d rdata=%h err=%b expected 3/1/0/0",
               lat, pulses, rd, err);
    end
    do_req(1'b0, 2'd2, 1'b0, 7'h0C, 32'h0, rdy, lat, pulses, rd, err, we_cyc, wa, wd, a1);
    checks++;
    if (rd !== 32'hBEEF6655 || lat != 2) begin
      errors++;
      $display("FAIL sh_readback: got %h lat=%0d expected beef6655 lat=2", rd, lat);
    end
  endtask

  task automatic test_store_word();
    logic rdy, err; int lat, pulses, we_cyc;
    logic [31:0] rd, wd; logic [4:0] wa, a1;
    do_req(1'b1, 2'd2, 1'b0, 7'h7C, 32'hDEADBEEF, rdy, lat, pulses, rd, err, we_cyc, wa, wd, a1);
    checks++;
    if (we_cyc != 1 || wa !== 5'd31 || wd !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL sw_write: got we_cycle=%0d addr=%0d data=%h expected 1/31/deadbeef",
               we_cyc, wa, wd);
    end
    checks++;
    if (lat != 2 || pulses != 1 || rd !== 32'h0) begin
      errors++;
      $display("FAIL sw_rsp: got lat=%0d pulses=%0d rdata=%h expected 2/1/0", lat, pulses, rd);
    end
    do_req(1'b0, 2'd2, 1'b0, 7'h7C, 32'h0, rdy, lat, pulses, rd, err, we_cyc, wa, wd, a1);
    checks++;
    if (rd !== 32'hDEADBEEF || lat != 2) begin
      errors++;
      $display("FAIL sw_readback: got %h lat=%0d expected deadbeef lat=2", rd, lat);
    end
    do_req(1'b1, 2'd0, 1'b0, 7'h7D, 32'h00000012, rdy, lat, pulses, rd, err, we_cyc, wa, wd, a1);
    checks++;
    if (we_cyc != 2 || wa !== 5'd31 || wd !== 32'hDEAD12EF || lat != 3) begin
      errors++;
      $display("FAIL sb_top_word: got we_cycle=%0d addr=%0d data=%h lat=%0d expected 2/31/dead12ef/3",
               we_cyc, wa, wd, lat);
    end
  endtask

  task automatic test_misalign();
    logic rdy, err; int lat, pulses, we_cyc;
    logic [31:0] rd, wd; logic [4:0] wa, a1;
    do_req(1'b0, 2'd2, 1'b0, 7'h0A, 32'h0, rdy, lat, pulses, rd, err, we_cyc, wa, wd, a1);
    checks++;
`ifdef LSU_MISALIGN_TRAP_EN
    if (lat != 1 || err !== 1'b1 || rd !== 32'h0 || we_cyc != 0) begin
      errors++;
      $display("FAIL lw_misalign: got lat=%0d err=%b rdata=%h we_cycle=%0d expected 1/1/0/0",
               lat, err, rd, we_cyc);
    end
`else
    if (lat != 2 || err !== 1'b0 || rd !== 32'h01020304 || we_cyc != 0) begin
      errors++;
      $display("FAIL lw_misalign: got lat=%0d err=%b rdata=%h we_cycle=%0d expected 2/0/01020304/0",
               lat, err, rd, we_cyc);
    end
`endif
    do_req(1'b0, 2'd3, 1'b0, 7'h09, 32'h0, rdy, lat, pulses, rd, err, we_cyc, wa, wd, a1);
    checks++;
`ifdef LSU_MISALIGN_TRAP_EN
    if (lat != 1 || err !== 1'b1 || rd !== 32'h0) begin
      errors++;
      $display("FAIL size3_load: got lat=%0d err=%b rdata=%h expected 1/1/0", lat, err, rd);
    end
`else
    if (lat != 2 || err !== 1'b0 || rd !== 32'h01020304) begin
      errors++;
      $display("FAIL size3_load: got lat=%0d err=%b rdata=%h expected 2/0/01020304", lat, err, rd);
    end
`endif
    do_req(1'b1, 2'd1, 1'b0, 7'h0F, 32'h0000AAAA, rdy, lat, pulses, rd, err, we_cyc, wa, wd, a1);
    checks++;
`ifdef LSU_MISALIGN_TRAP_EN
    if (lat != 1 || err !== 1'b1 || we_cyc != 0) begin
      errors++;
      $display("FAIL sh_misalign: got lat=%0d err=%b we_cycle=%0d expected 1/1/0", lat, err, we_cyc);
    end
`else
    if (lat != 3 || err !== 1'b0 || we_cyc != 2 || wa !== 5'd3 || wd !== 32'hAAAA6655) begin
      errors++;
      $display("FAIL sh_misalign: got lat=%0d err=%b we_cycle=%0d addr=%0d data=%h expected 3/0/2/3/aaaa6655",
               lat, err, we_cyc, wa, wd);
    end
`endif
  endtask

  task automatic test_reset_mid_op();
    logic rdy, err; int lat, pulses, we_cyc;
    logic [31:0] rd, wd; logic [4:0] wa, a1;
    int rsp_cnt;
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = 7'h14; req_wdata = 32'h000000AA;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_accept: got ready=%b expected 1", req_ready);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (mem_we !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_wr_cycle: got we=%b rsp_valid=%b ready=%b expected 0/0/0",
               mem_we, rsp_valid, req_ready);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    rsp_cnt = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k == 0) begin
        checks++;
        if (req_ready !== 1'b1) begin
          errors++;
          $display("FAIL rst_mid_ready: got %b expected 1", req_ready);
        end
      end
      if (rsp_valid) rsp_cnt++;
      @(posedge clk); #1;
    end
    checks++;
    if (rsp_cnt != 0 || mem[5] !== 32'h11111111) begin
      errors++;
      $display("FAIL rst_mid_effect: got rsp=%0d word5=%h expected 0/11111111", rsp_cnt, mem[5]);
    end
    do_req(1'b0, 2'd2, 1'b0, 7'h14, 32'h0, rdy, lat, pulses, rd, err, we_cyc, wa, wd, a1);
    checks++;
    if (rd !== 32'h11111111 || lat != 2) begin
      errors++;
      $display("FAIL rst_mid_readback: got %h lat=%0d expected 11111111 lat=2", rd, lat);
    end
  endtask

  // ---------------- sequence and final report ----------------
  initial begin
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = 7'h0; req_wdata = 32'h0;
    pre_we = 1'b0; pre_addr = 5'h0; pre_data = 32'h0;
    test_reset();
    preload(5'd2, 32'h01020304);
    preload(5'd3, 32'h88776655);
    preload(5'd5, 32'h11111111);
    test_load();
    test_back_to_back();
    test_store_half();
    test_store_word();
    test_misalign();
    test_reset_mid_op();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
- Load/store initiator sitting between the core's execute stage and the 32-word data memory.
- Accepts byte, half and word load/store requests over a valid/ready handshake.
- Drives the memory's word-granular port (write enable, word address, write data) and samples its combinational read data.
- Sub-word stores use an internal read-modify-write; loads return sign- or zero-extended results on a one-cycle response pulse.

Parameters:
ADDR_W, 5, word-address width (memory depth 2**ADDR_W words)
XLEN, 32, data width; the only supported value is 32

Ports:
clk_i  in  1  clock, all state on rising edge
rst_i  in  1  synchronous active-high reset
req_valid_i  in  1  request valid
req_ready_o  out  1  request ready; a request is accepted when valid and ready are both 1
req_we_i  in  1  1 = store, 0 = load
req_size_i  in  2  00 byte, 01 half, 10 word, 11 illegal
req_unsigned_i  in  1  loads only: 1 = zero-extend, 0 = sign-extend
req_addr_i  in  ADDR_W+2  byte address
req_wdata_i  in  XLEN  store data, right-aligned
rsp_valid_o  out  1  one-cycle response pulse
rsp_rdata_o  out  XLEN  load result; 0 for stores and errors
rsp_err_o  out  1  misaligned or illegal request; qualified by rsp_valid_o
mem_we_o  out  1  memory write enable; write commits at the rising edge while high
mem_addr_o  out  ADDR_W  memory word address
mem_wdata_o  out  XLEN  memory write data
mem_rdata_i  in  XLEN  memory read data, combinational from mem_addr_o when mem_we_o=0

Behaviour:
- Clocking and reset: single clock clk_i. Reset rst_i is synchronous and active-high.
- Reset state: state=IDLE, rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0.
- req_ready_o = (state==IDLE) && !rst_i.
- mem_we_o is gated by !rst_i, so no write commits in any cycle with rst_i high.
- FSM states: IDLE, RD, WR, RSP.
- IDLE:
  - mem_we_o=0, mem_addr_o=0, mem_wdata_o=0.
  - On accept, latch we, size, unsigned, addr, wdata.
  - Error request -> RSP with err=1.
  - Load -> RD.
  - Word store -> WR.
  - Byte/half store -> RD.
- RD:
  - mem_we_o=0, mem_addr_o=addr[ADDR_W+1:2].
  - At cycle end, capture mem_rdata_i into the word buffer.
  - Load -> RSP, with data extracted using addr[1:0] and size: byte lane addr[1:0]; half lane addr[1]; then sign/zero extension.
  - Sub-word store -> WR.
- WR:
  - mem_we_o=1 for exactly one cycle; mem_addr_o as in RD.
  - Word store: mem_wdata_o = wdata.
  - Sub-word store: mem_wdata_o = buffer with the selected byte/half lane replaced by wdata[7:0] or wdata[15:0].
  - Next state: RSP.
- RSP:
  - rsp_valid_o=1 for exactly one cycle; no response backpressure.
  - Next state: IDLE, with ready re-asserted in the following cycle.
- Response latency from the accept cycle T:
  - error: rsp_valid_o at T+1
  - load: T+2
  - word store: T+2
  - sub-word store: T+3
- Error definition: size=11, half with addr[0]=1, or word with addr[1:0]!=0. Errors make no memory access (mem_we_o stays 0).
- Response data: rsp_rdata_o and rsp_err_o are valid only while rsp_valid_o=1 and are driven 0 otherwise.
- req_valid_i while not ready: ignored. The requester holds the request until accepted.
- Address wrap: byte address width is exactly ADDR_W+2; there is no out-of-range case.
- Reset mid-operation: abort to IDLE. A pending WR is not committed and no response is issued.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined: misaligned and illegal requests are flagged as described in Behaviour.
- Undefined:
  - rsp_err_o tied 0.
  - Misaligned half/word addresses are forced aligned by clearing addr[0] (half) or addr[1:0] (word).
  - size=11 is treated as word.
  - The access then proceeds normally with standard latency.

Test Plan:
- Preload word 3 = 0x88776655. lb addr 0x0D -> rsp at T+2, rdata 0x00000066, err 0. lb addr 0x0F -> 0xFFFFFF88. lbu addr 0x0F -> 0x00000088.
- sh wdata 0x1234BEEF addr 0x0E on word 3 = 0x88776655:
  - T+1: mem_we_o=0, mem_addr_o=3.
  - T+2: mem_we_o=1, mem_wdata_o=0xBEEF6655.
  - T+3: rsp_valid_o=1, rdata 0.
- sw 0xDEADBEEF addr 0x7C -> mem_we_o=1 at T+1 with mem_addr_o=31; rsp at T+2. Subsequent lw 0x7C -> 0xDEADBEEF.
- lw addr 0x0A, feature defined -> rsp at T+1, err 1, rdata 0, mem_we_o never high. Feature undefined -> word 2 read, err 0, rsp at T+2.
- Back-to-back: req_valid_i held high with 3 loads -> req_ready_o high only in IDLE cycles; accepts at T, T+3, T+6; exactly 3 rsp pulses.
- sb to word 5 = 0x11111111 with rst_i asserted during the WR cycle -> mem_we_o=0 in that cycle, word 5 still 0x11111111, no rsp_valid_o. req_ready_o=1 the cycle after rst_i deasserts.
